// File: rtl/cdma_rd_pkg.sv
// cdma_rd_pkg: shared types and AXI constants for the CDMA read engine.
// Holds the engine state enum, the AXI burst/response/cache encodings
// and the 4 KB page size that AR bursts must never cross.
package cdma_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ARCACHE    = 4'b0011;
  localparam logic [2:0] AXI_ARPROT     = 3'b000;
  localparam int         PAGE_BYTES     = 4096;

endpackage

// File: rtl/cdma_rd_burst_calc.sv
// cdma_rd_burst_calc: combinational length of the next AR burst.
// The burst is the smallest of the beats still to request, the
// configured maximum burst, and the beats left before the next 4 KB page.
module cdma_rd_burst_calc
  import cdma_rd_pkg::*;
#(
  parameter int BURST_LEN  = 64,
  parameter int BYTES_LOG2 = 5,
  parameter int BEAT_BITS  = 28
) (
  input  logic [11:0]          page_off,
  input  logic [BEAT_BITS-1:0] remaining,
  output logic [8:0]           beats
);

  localparam int CW = (BEAT_BITS > 13) ? BEAT_BITS : 13;

  logic [12:0]   page_left_bytes;
  logic [12:0]   page_left_beats;
  logic [CW-1:0] cap;
  logic [CW-1:0] rem_ext;
  logic [CW-1:0] pick;

  // Clamp the remaining beats to the page limit and the burst limit
  always_comb begin
    page_left_bytes = 13'(PAGE_BYTES) - {1'b0, page_off};
    page_left_beats = page_left_bytes >> BYTES_LOG2;
    cap             = CW'(page_left_beats);
    if (CW'(BURST_LEN) < cap) begin
      cap = CW'(BURST_LEN);
    end
    rem_ext = CW'(remaining);
    pick    = (rem_ext < cap) ? rem_ext : cap;
    beats   = 9'(pick);
  end

endmodule

// File: rtl/cdma_rd_engine.sv
// cdma_rd_engine: AXI4 read DMA (MM2S). Splits one (address, length)
// command into INCR bursts that never cross 4 KB, keeps up to
// N_OUTSTANDING bursts in flight, and forwards R data unbuffered as a
// single AXI4-Stream packet with tkeep trimmed on the final beat.
// Optional feature macro: CDMA_RD_RRESP_EN (sticky rresp error on rd_err).
module cdma_rd_engine
  import cdma_rd_pkg::*;
#(
  parameter int BURST_LEN     = 64,
  parameter int DATA_BITS     = 256,
  parameter int ADDR_BITS     = 64,
  parameter int ID_BITS       = 2,
  parameter int LEN_BITS      = 32,
  parameter int N_OUTSTANDING = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // command
  input  logic                   rd_valid,
  output logic                   rd_ready,
  input  logic [ADDR_BITS-1:0]   rd_paddr,
  input  logic [LEN_BITS-1:0]    rd_len,
  output logic                   rd_done,
  output logic                   rd_err,
  // AXI4 read address
  output logic [ID_BITS-1:0]     m_axi_ddr_arid,
  output logic [ADDR_BITS-1:0]   m_axi_ddr_araddr,
  output logic [7:0]             m_axi_ddr_arlen,
  output logic [2:0]             m_axi_ddr_arsize,
  output logic [1:0]             m_axi_ddr_arburst,
  output logic [3:0]             m_axi_ddr_arcache,
  output logic [2:0]             m_axi_ddr_arprot,
  output logic                   m_axi_ddr_arvalid,
  input  logic                   m_axi_ddr_arready,
  // AXI4 read data
  input  logic [ID_BITS-1:0]     m_axi_ddr_rid,
  input  logic [DATA_BITS-1:0]   m_axi_ddr_rdata,
  input  logic [1:0]             m_axi_ddr_rresp,
  input  logic                   m_axi_ddr_rlast,
  input  logic                   m_axi_ddr_rvalid,
  output logic                   m_axi_ddr_rready,
  // AXI4 write channels, unused by a read engine
  output logic [ID_BITS-1:0]     m_axi_ddr_awid,
  output logic [ADDR_BITS-1:0]   m_axi_ddr_awaddr,
  output logic [7:0]             m_axi_ddr_awlen,
  output logic [2:0]             m_axi_ddr_awsize,
  output logic [1:0]             m_axi_ddr_awburst,
  output logic                   m_axi_ddr_awvalid,
  input  logic                   m_axi_ddr_awready,
  output logic [DATA_BITS-1:0]   m_axi_ddr_wdata,
  output logic [DATA_BITS/8-1:0] m_axi_ddr_wstrb,
  output logic                   m_axi_ddr_wlast,
  output logic                   m_axi_ddr_wvalid,
  input  logic                   m_axi_ddr_wready,
  input  logic [ID_BITS-1:0]     m_axi_ddr_bid,
  input  logic [1:0]             m_axi_ddr_bresp,
  input  logic                   m_axi_ddr_bvalid,
  output logic                   m_axi_ddr_bready,
  // AXI4-Stream output
  output logic [DATA_BITS-1:0]   m_axis_ddr_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_ddr_tkeep,
  output logic                   m_axis_ddr_tlast,
  output logic                   m_axis_ddr_tvalid,
  input  logic                   m_axis_ddr_tready
);

  localparam int BYTES      = DATA_BITS / 8;
  localparam int BYTES_LOG2 = $clog2(BYTES);
  localparam int BEAT_BITS  = LEN_BITS - BYTES_LOG2 + 1;
  localparam int OUT_BITS   = $clog2(N_OUTSTANDING + 1);

  rd_state_e             state;
  rd_state_e             state_next;
  logic [ADDR_BITS-1:0]  cur_addr;
  logic [BEAT_BITS-1:0]  remaining;
  logic [BEAT_BITS-1:0]  total_beats;
  logic [BEAT_BITS-1:0]  rcv_cnt;
  logic [BYTES_LOG2-1:0] tail;
  logic [OUT_BITS-1:0]   outstanding;
  logic [8:0]            burst_beats;

  logic                  busy;
  logic                  cmd_accept;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  rlast_fire;
  logic                  last_beat;
  logic                  final_fire;
  logic [LEN_BITS:0]     len_round;
  logic [BEAT_BITS-1:0]  cmd_beats;
  logic [BYTES:0]        tail_one;
  logic [BYTES-1:0]      tail_mask;
  logic                  unused_inputs;

  cdma_rd_burst_calc #(
    .BURST_LEN  (BURST_LEN),
    .BYTES_LOG2 (BYTES_LOG2),
    .BEAT_BITS  (BEAT_BITS)
  ) u_burst_calc (
    .page_off  (cur_addr[11:0]),
    .remaining (remaining),
    .beats     (burst_beats)
  );

  assign len_round  = {1'b0, rd_len} + (LEN_BITS+1)'(BYTES - 1);
  assign cmd_beats  = BEAT_BITS'(len_round >> BYTES_LOG2);

  assign busy       = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign cmd_accept = rd_valid && rd_ready;
  assign ar_fire    = m_axi_ddr_arvalid && m_axi_ddr_arready;
  assign r_fire     = busy && m_axi_ddr_rvalid && m_axi_ddr_rready;
  assign rlast_fire = r_fire && m_axi_ddr_rlast;
  assign last_beat  = (rcv_cnt == total_beats - BEAT_BITS'(1));
  assign final_fire = r_fire && last_beat;

  assign m_axi_ddr_arid    = '0;
  assign m_axi_ddr_araddr  = cur_addr;
  assign m_axi_ddr_arlen   = 8'(burst_beats - 9'd1);
  assign m_axi_ddr_arsize  = 3'(BYTES_LOG2);
  assign m_axi_ddr_arburst = AXI_BURST_INCR;
  assign m_axi_ddr_arcache = AXI_ARCACHE;
  assign m_axi_ddr_arprot  = AXI_ARPROT;

  // R data goes straight to the stream; only reset blocks the path
  assign m_axi_ddr_rready  = m_axis_ddr_tready && aresetn;
  assign m_axis_ddr_tvalid = m_axi_ddr_rvalid && aresetn;
  assign m_axis_ddr_tdata  = m_axi_ddr_rdata;
  assign m_axis_ddr_tlast  = last_beat;

  assign tail_one          = (BYTES+1)'(1) << tail;
  assign tail_mask         = BYTES'(tail_one - (BYTES+1)'(1));
  assign m_axis_ddr_tkeep  = (last_beat && (tail != '0)) ? tail_mask : '1;

  assign m_axi_ddr_awid    = '0;
  assign m_axi_ddr_awaddr  = '0;
  assign m_axi_ddr_awlen   = '0;
  assign m_axi_ddr_awsize  = '0;
  assign m_axi_ddr_awburst = '0;
  assign m_axi_ddr_awvalid = 1'b0;
  assign m_axi_ddr_wdata   = '0;
  assign m_axi_ddr_wstrb   = '0;
  assign m_axi_ddr_wlast   = 1'b0;
  assign m_axi_ddr_wvalid  = 1'b0;
  assign m_axi_ddr_bready  = 1'b0;

  assign unused_inputs = ^{m_axi_ddr_rid, m_axi_ddr_awready, m_axi_ddr_wready,
                           m_axi_ddr_bid, m_axi_ddr_bresp, m_axi_ddr_bvalid,
                           (m_axi_ddr_rresp != AXI_RESP_OKAY)};

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs of the command sequencer
  always_comb begin
    state_next        = state;
    rd_ready          = 1'b0;
    rd_done           = 1'b0;
    m_axi_ddr_arvalid = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_ready = aresetn;
        if (rd_valid && aresetn) begin
          state_next = (rd_len == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_axi_ddr_arvalid = (outstanding != OUT_BITS'(N_OUTSTANDING));
        if (m_axi_ddr_arvalid && m_axi_ddr_arready &&
            (remaining == BEAT_BITS'(burst_beats))) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (final_fire || (rcv_cnt == total_beats)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        rd_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the command, then walk address and remaining beats per AR
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cur_addr    <= '0;
      remaining   <= '0;
      total_beats <= '0;
      tail        <= '0;
    end else if (cmd_accept) begin
      cur_addr    <= rd_paddr;
      remaining   <= cmd_beats;
      total_beats <= cmd_beats;
      tail        <= rd_len[BYTES_LOG2-1:0];
    end else if (ar_fire) begin
      cur_addr    <= cur_addr + (ADDR_BITS'(burst_beats) << BYTES_LOG2);
      remaining   <= remaining - BEAT_BITS'(burst_beats);
    end
  end

  // Count beats delivered to the stream for tlast/tkeep and completion
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rcv_cnt <= '0;
    end else if (cmd_accept) begin
      rcv_cnt <= '0;
    end else if (r_fire) begin
      rcv_cnt <= rcv_cnt + BEAT_BITS'(1);
    end
  end

  // Track bursts issued but not yet closed by rlast
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else if (ar_fire && !rlast_fire) begin
      outstanding <= outstanding + OUT_BITS'(1);
    end else if (!ar_fire && rlast_fire) begin
      outstanding <= outstanding - OUT_BITS'(1);
    end
  end

`ifdef CDMA_RD_RRESP_EN
  logic err_sticky;

  // Accumulate any non-OKAY response over the whole command
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_sticky <= 1'b0;
    end else if (cmd_accept) begin
      err_sticky <= 1'b0;
    end else if (r_fire && (m_axi_ddr_rresp != AXI_RESP_OKAY)) begin
      err_sticky <= 1'b1;
    end
  end

  assign rd_err = rd_done && err_sticky;
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdma_rd_engine.sv
// tb_cdma_rd_engine: scoreboard bench for cdma_rd_engine with a small
// AXI4 read slave model. Stimulus pushes expected AR, stream beats and
// completions into queues; a negedge monitor pops and compares them.
module tb_cdma_rd_engine;

  localparam int DB = 256;
  localparam int AB = 64;
  localparam int IB = 2;
  localparam int LB = 32;
  localparam int NO = 2;
  localparam int BY = DB / 8;

  typedef struct packed {
    logic [DB-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [7:0]    len;
  } ar_t;

  typedef struct packed {
    logic err;
    logic zero;
    int   cyc;
  } done_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AB-1:0] rd_paddr = '0;
  logic [LB-1:0] rd_len = '0;
  logic          rd_done;
  logic          rd_err;

  logic [IB-1:0] arid;
  logic [AB-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready = 1'b1;
  logic [IB-1:0] rid = '0;
  logic [DB-1:0] rdata = '0;
  logic [1:0]    rresp = 2'b00;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [IB-1:0] awid;
  logic [AB-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic [DB-1:0] wdata;
  logic [BY-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          bready;
  logic [DB-1:0] tdata;
  logic [BY-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready = 1'b0;

  beat_t exp_beat_q[$];
  ar_t   exp_ar_q[$];
  done_t exp_done_q[$];
  ar_t   slave_q[$];

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  done_seen = 0;
  int  done_target = 0;
  int  last_cyc = 0;
  int  out_cnt = 0;
  int  beats_issued = 0;
  int  err_beat_abs = -1;
  int  beat_no = 0;
  bit  bp_mode = 1'b0;
  bit  r_hs = 1'b0;
  bit  was_reset = 1'b0;
  bit  timeout_flag = 1'b0;
  bit  timeout_reported = 1'b0;
  bit  final_req = 1'b0;
  bit  final_done = 1'b0;

  beat_t eb;
  ar_t   ea;
  done_t ed;

  cdma_rd_engine #(
    .BURST_LEN     (64),
    .DATA_BITS     (DB),
    .ADDR_BITS     (AB),
    .ID_BITS       (IB),
    .LEN_BITS      (LB),
    .N_OUTSTANDING (NO)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_paddr          (rd_paddr),
    .rd_len            (rd_len),
    .rd_done           (rd_done),
    .rd_err            (rd_err),
    .m_axi_ddr_arid    (arid),
    .m_axi_ddr_araddr  (araddr),
    .m_axi_ddr_arlen   (arlen),
    .m_axi_ddr_arsize  (arsize),
    .m_axi_ddr_arburst (arburst),
    .m_axi_ddr_arcache (arcache),
    .m_axi_ddr_arprot  (arprot),
    .m_axi_ddr_arvalid (arvalid),
    .m_axi_ddr_arready (arready),
    .m_axi_ddr_rid     (rid),
    .m_axi_ddr_rdata   (rdata),
    .m_axi_ddr_rresp   (rresp),
    .m_axi_ddr_rlast   (rlast),
    .m_axi_ddr_rvalid  (rvalid),
    .m_axi_ddr_rready  (rready),
    .m_axi_ddr_awid    (awid),
    .m_axi_ddr_awaddr  (awaddr),
    .m_axi_ddr_awlen   (awlen),
    .m_axi_ddr_awsize  (awsize),
    .m_axi_ddr_awburst (awburst),
    .m_axi_ddr_awvalid (awvalid),
    .m_axi_ddr_awready (1'b0),
    .m_axi_ddr_wdata   (wdata),
    .m_axi_ddr_wstrb   (wstrb),
    .m_axi_ddr_wlast   (wlast),
    .m_axi_ddr_wvalid  (wvalid),
    .m_axi_ddr_wready  (1'b0),
    .m_axi_ddr_bid     (2'b00),
    .m_axi_ddr_bresp   (2'b00),
    .m_axi_ddr_bvalid  (1'b0),
    .m_axi_ddr_bready  (bready),
    .m_axis_ddr_tdata  (tdata),
    .m_axis_ddr_tkeep  (tkeep),
    .m_axis_ddr_tlast  (tlast),
    .m_axis_ddr_tvalid (tvalid),
    .m_axis_ddr_tready (tready)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Data word the slave returns for a given beat address
  function automatic logic [DB-1:0] beatData(input logic [AB-1:0] a);
    logic [DB-1:0] d;
    for (int k = 0; k < 8; k++) begin
      d[k*32 +: 32] = a[31:0] + 32'(k) * 32'h0101_0101;
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [DB-1:0] act,
                             input logic [DB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failUnexpected(input string name, input logic [DB-1:0] act);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic expectAr(input logic [AB-1:0] addr, input logic [7:0] len);
    ar_t a;
    a.addr = addr;
    a.len  = len;
    exp_ar_q.push_back(a);
  endtask

  task automatic applyStimulus(input logic [AB-1:0] paddr, input logic [LB-1:0] len,
                               input int err_idx);
    int    nb;
    int    tl;
    int    waited;
    beat_t b;
    done_t d;
    waited = 0;
    while (!rd_ready && waited < 1000) begin
      @(posedge aclk); #1;
      waited++;
    end
    nb = (int'(len) + 31) / 32;
    tl = int'(len) % 32;
    for (int i = 0; i < nb; i++) begin
      b.data = beatData(paddr + 64'(i * 32));
      b.keep = (i == nb - 1 && tl != 0) ? BY'((33'd1 << tl) - 33'd1) : '1;
      b.last = (i == nb - 1);
      exp_beat_q.push_back(b);
    end
    err_beat_abs = (err_idx < 0) ? -1 : beats_issued + err_idx;
    beats_issued += nb;
`ifdef CDMA_RD_RRESP_EN
    d.err = (err_idx >= 0);
`else
    d.err = 1'b0;
`endif
    d.zero = (len == '0);
    d.cyc  = cyc + 1;
    exp_done_q.push_back(d);
    rd_paddr = paddr;
    rd_len   = len;
    rd_valid = 1'b1;
    @(posedge aclk); #1;
    rd_valid = 1'b0;
    done_target++;
    waited = 0;
    while (done_seen < done_target && waited < 20000) begin
      @(posedge aclk); #1;
      waited++;
    end
    if (done_seen < done_target) timeout_flag = 1'b1;
  endtask

  // Stream sink: always ready, or random ready in backpressure mode
  initial begin
    forever begin
      @(posedge aclk); #1;
      tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // AXI read slave: serves accepted bursts in order, random gaps in bp_mode
  initial begin
    logic     r_active;
    logic [AB-1:0] r_addr;
    int       r_left;
    ar_t      sb;
    r_active = 1'b0;
    r_addr   = '0;
    r_left   = 0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        rvalid   = 1'b0;
        r_active = 1'b0;
      end else begin
        if (rvalid && r_hs) begin
          rvalid = 1'b0;
          r_addr = r_addr + 64'd32;
          r_left--;
          beat_no++;
          if (r_left == 0) r_active = 1'b0;
        end
        if (!rvalid) begin
          if (!r_active && slave_q.size() > 0) begin
            sb       = slave_q.pop_front();
            r_addr   = sb.addr;
            r_left   = int'(sb.len) + 1;
            r_active = 1'b1;
          end
          if (r_active && (!bp_mode || $urandom_range(0, 2) == 0)) begin
            rvalid = 1'b1;
            rdata  = beatData(r_addr);
            rlast  = (r_left == 1);
            rresp  = (beat_no == err_beat_abs) ? 2'b10 : 2'b00;
          end
        end
      end
    end
  end

  // Monitor: sample away from the active edge and score every handshake
  always @(negedge aclk) begin
    r_hs = rvalid && rready;
    if (!aresetn) begin
      checkOutput("reset outputs", 256'({rd_ready, rd_done, rd_err, arvalid, rready, tvalid}),
                  256'(0));
      was_reset = 1'b1;
    end else begin
      if (was_reset) begin
        checkOutput("rd_ready after reset", 256'(rd_ready), 256'(1));
        was_reset = 1'b0;
      end
      checkOutput("rready follows tready", 256'(rready), 256'(tready));
      if (tvalid && tready) begin
        if (exp_beat_q.size() == 0) begin
          failUnexpected("stream beat", tdata);
        end else begin
          eb = exp_beat_q.pop_front();
          checkOutput("tdata", tdata, eb.data);
          checkOutput("tkeep", 256'(tkeep), 256'(eb.keep));
          checkOutput("tlast", 256'(tlast), 256'(eb.last));
        end
        if (tlast) last_cyc = cyc;
      end
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) begin
          failUnexpected("ar request", 256'(araddr));
        end else begin
          ea = exp_ar_q.pop_front();
          checkOutput("araddr", 256'(araddr), 256'(ea.addr));
          checkOutput("arlen", 256'(arlen), 256'(ea.len));
          checkOutput("ar attributes", 256'({arid, arsize, arburst, arcache, arprot}),
                      256'({2'b00, 3'd5, 2'b01, 4'b0011, 3'b000}));
        end
        slave_q.push_back('{araddr, arlen});
      end
      out_cnt = out_cnt + ((arvalid && arready) ? 1 : 0) - ((rvalid && rready && rlast) ? 1 : 0);
      if (arvalid && arready) begin
        checkOutput("outstanding limit", 256'(out_cnt <= NO), 256'(1));
      end
      if (rd_done) begin
        done_seen++;
        if (exp_done_q.size() == 0) begin
          failUnexpected("rd_done", 256'(rd_err));
        end else begin
          ed = exp_done_q.pop_front();
          checkOutput("rd_err", 256'(rd_err), 256'(ed.err));
          checkOutput("rd_done timing", 256'(cyc), ed.zero ? 256'(ed.cyc) : 256'(last_cyc + 1));
        end
      end
      if (timeout_flag && !timeout_reported) begin
        failUnexpected("rd_done timeout", 256'(done_seen));
        timeout_reported = 1'b1;
      end
      if (final_req && !final_done) begin
        checkOutput("leftover expectations",
                    256'({16'(exp_beat_q.size()), 16'(exp_ar_q.size()), 16'(exp_done_q.size())}),
                    256'(0));
        final_done = 1'b1;
      end
    end
  end

  initial begin
    aresetn = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Two full 64-beat bursts inside one page
    expectAr(64'h1000, 8'd63);
    expectAr(64'h1800, 8'd63);
    applyStimulus(64'h1000, 32'd4096, -1);

    // Split at the 4 KB boundary: 4 beats then 12 beats
    expectAr(64'h1F80, 8'd3);
    expectAr(64'h2000, 8'd11);
    applyStimulus(64'h1F80, 32'd512, -1);

    // 100 bytes: 4 beats, final tkeep 32'h0000000F
    expectAr(64'h0, 8'd3);
    applyStimulus(64'h0, 32'd100, -1);

    // Zero length: no AR, no beat, completion right after acceptance
    applyStimulus(64'h5000, 32'd0, -1);

    // Backpressure: 512 beats in 8 bursts, delayed R, random tready
    bp_mode = 1'b1;
    for (int k = 0; k < 8; k++) begin
      expectAr(64'h20000 + 64'(k) * 64'h800, 8'd63);
    end
    applyStimulus(64'h20000, 32'd16384, -1);
    bp_mode = 1'b0;

    // SLVERR on beat 2 of 4, then a clean command
    expectAr(64'h3000, 8'd3);
    applyStimulus(64'h3000, 32'd128, 1);
    expectAr(64'h3000, 8'd3);
    applyStimulus(64'h3000, 32'd128, -1);

    repeat (4) @(posedge aclk);
    #1;
    final_req = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge aclk);
    repeat (2) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
